mxint_cast_scheduler: RTL
=========================

MXINT_CAST_SCHEDULER -- requirements
Module: mxint_cast_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_REQ, 2: number of requesters sharing one mxint_cast instance; 2..8.
- MAN_WIDTH, 8: mantissa width on both the requester side and the cast-input side.
- EXP_WIDTH, 8: exponent width on both the requester side and the cast-input side.
- OUT_MAN_WIDTH, 8: cast-output mantissa width.
- OUT_EXP_WIDTH, 8: cast-output exponent width.
- BLOCK_SIZE, 4: mantissas per beat.
- TAG_DEPTH, 4: in-flight beat capacity; power of 2, minimum 2.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst, in, 1: asynchronous, active-low reset.
- req_mdata_in, in, [NUM_REQ][BLOCK_SIZE] x MAN_WIDTH signed: requester mantissas.
- req_edata_in, in, [NUM_REQ] x EXP_WIDTH: requester exponents.
- req_valid, in, NUM_REQ: per-requester valid.
- req_ready, out, NUM_REQ: per-requester ready.
- cast_mdata_in, out, [BLOCK_SIZE] x MAN_WIDTH: mantissas to the shared cast unit.
- cast_edata_in, out, EXP_WIDTH: exponent to the shared cast unit.
- cast_in_valid, out, 1: valid to the cast unit.
- cast_in_ready, in, 1: ready from the cast unit.
- cast_mdata_out, in, [BLOCK_SIZE] x OUT_MAN_WIDTH: mantissas from the cast unit.
- cast_edata_out, in, OUT_EXP_WIDTH: exponent from the cast unit.
- cast_out_valid, in, 1: valid from the cast unit.
- cast_out_ready, out, 1: ready to the cast unit.
- resp_mdata_out, out, [BLOCK_SIZE] x OUT_MAN_WIDTH: result mantissas, broadcast to all requesters.
- resp_edata_out, out, OUT_EXP_WIDTH: result exponent, broadcast to all requesters.
- resp_valid, out, NUM_REQ: one-hot response valid.
- resp_ready, in, NUM_REQ: per-requester response ready.
- outstanding, out, $clog2(TAG_DEPTH)+1: number of beats issued but not yet returned.

Function
REQ-003 Issue arbitration SHALL be round-robin: the grant goes to the first asserted req_valid at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-004 Issue fire SHALL be defined as cast_in_valid && cast_in_ready.
- On each issue fire, rr_ptr SHALL become (grant+1) mod NUM_REQ.
- Without an issue fire, rr_ptr SHALL hold.
REQ-005 cast_in_valid SHALL equal (|req_valid) && !tag_full, where tag_full is registered and means count == TAG_DEPTH.
REQ-006 A lock register SHALL capture the grant whenever cast_in_valid=1 and cast_in_ready=0.
- While locked, the grant and the cast_mdata_in/cast_edata_in selection SHALL NOT change.
- The lock SHALL clear on the next issue fire.
REQ-007 Requesters SHALL hold req_valid and data until accepted; behaviour on violation is not required.
REQ-008 req_ready[i] SHALL be 1 only when i == grant, cast_in_ready=1, and tag_full=0; at most one bit is set per cycle.
REQ-009 Issue path latency: cast_in_* SHALL be combinational from req_* through the grant mux, with zero cycles added.
REQ-010 The tag FIFO (TAG_DEPTH entries, $clog2(NUM_REQ) bits each) SHALL push the grant index on each issue fire.
REQ-011 Return path:
- With the tag FIFO non-empty and head tag h, resp_valid SHALL be one-hot at bit h, equal to cast_out_valid.
- cast_out_ready SHALL equal resp_ready[h].
- resp_mdata_out/resp_edata_out SHALL pass cast_mdata_out/cast_edata_out through unchanged.
REQ-012 With the tag FIFO empty:
- cast_out_ready=0 and resp_valid=0.
- A cast_out_valid arriving in this state is a protocol error; the sticky internal flag err_orphan SHALL be set and exposed for assertion.
REQ-013 A return fire (cast_out_valid && cast_out_ready) SHALL pop the tag FIFO.
REQ-014 A push and a pop in the same cycle SHALL leave the count unchanged. When full, a push is blocked even if a pop occurs in the same cycle.
REQ-015 outstanding SHALL equal the tag FIFO count, updated the cycle after each fire. Read/write pointers SHALL wrap modulo TAG_DEPTH.
REQ-016 Responses SHALL return in issue order, since the cast unit is in-order. No reordering is permitted.

Reset
REQ-017 While rst=0, asynchronously:
- rr_ptr=0, lock cleared, tag FIFO empty, outstanding=0, err_orphan=0.
- Therefore cast_in_valid=0, req_ready=0, cast_out_ready=0, resp_valid=0.
REQ-018 Reset mid-operation SHALL discard all in-flight tags. Any cast-unit data still in flight is not delivered; the system SHALL reset the cast unit together with this block.
REQ-019 The first issue after reset release SHALL be at the earliest the first rising edge with rst=1.

Verification
REQ-020 NUM_REQ=2, both req_valid=1 continuously, cast_in_ready=1 -> grants alternate 0,1,0,1; tag FIFO contents 0,1,0,1.
REQ-021 Only req 1 is valid with cast_in_ready=0 for 3 cycles, then req 0 raises valid -> grant stays 1 until the fire, then passes to 0 on the next cycle.
REQ-022 TAG_DEPTH=4, cast_out_valid=0, 5 issue attempts -> 4 accepted; outstanding=4; cast_in_valid=0; req_ready=0 until one return fire.
REQ-023 Issue order 1,0,1 with the cast returning edata 0x10, 0x20, 0x30 -> resp_valid = 0b10, 0b01, 0b10 in sequence, with matching data. With resp_ready[1]=0 on the first response, cast_out_ready=0 is held until the requester accepts.
REQ-024 Simultaneous issue and return fire with outstanding=2 -> outstanding stays 2; head tag advances.
REQ-025 rst asserted with outstanding=3 -> outputs are at reset values the same cycle; after release the first grant goes to req 0.

Source files
------------

// File: rtl/mxint_cast_scheduler.sv
// mxint_cast_scheduler
// Shares one mxint_cast instance among NUM_REQ requesters. Requests are
// arbitrated round-robin and forwarded to the cast unit with no added latency.
// The index of each issued beat is recorded in a tag FIFO. Because the cast
// unit is in-order, the tag at the FIFO head names the requester that owns the
// next result, so the result is routed back to that requester only.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   req_*               per-requester beats (mantissas, exponent, valid/ready)
//   cast_*_in, cast_in_*    issue side toward the cast unit
//   cast_*_out, cast_out_*  result side from the cast unit
//   resp_*              result broadcast, with one-hot resp_valid
//   outstanding         beats issued and not yet returned (tag FIFO count)
//   err_orphan          sticky: cast unit returned a beat with no tag in flight
//   arb_locked          debug: arbiter state (1 = grant frozen by a stalled issue)
//
// Handshakes: each channel transfers a beat on a cycle where valid && ready.
// A source holds valid and data stable until that cycle. Ready may depend
// combinationally on valid.
module mxint_cast_scheduler #(
    parameter int NUM_REQ       = 2,
    parameter int MAN_WIDTH     = 8,
    parameter int EXP_WIDTH     = 8,
    parameter int OUT_MAN_WIDTH = 8,
    parameter int OUT_EXP_WIDTH = 8,
    parameter int BLOCK_SIZE    = 4,
    parameter int TAG_DEPTH     = 4
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic signed [NUM_REQ-1:0][BLOCK_SIZE-1:0][MAN_WIDTH-1:0] req_mdata_in,
    input  logic [NUM_REQ-1:0][EXP_WIDTH-1:0]                     req_edata_in,
    input  logic [NUM_REQ-1:0]                                    req_valid,
    output logic [NUM_REQ-1:0]                                    req_ready,
    output logic [BLOCK_SIZE-1:0][MAN_WIDTH-1:0]                  cast_mdata_in,
    output logic [EXP_WIDTH-1:0]                                  cast_edata_in,
    output logic                                                  cast_in_valid,
    input  logic                                                  cast_in_ready,
    input  logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0]              cast_mdata_out,
    input  logic [OUT_EXP_WIDTH-1:0]                              cast_edata_out,
    input  logic                                                  cast_out_valid,
    output logic                                                  cast_out_ready,
    output logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0]              resp_mdata_out,
    output logic [OUT_EXP_WIDTH-1:0]                              resp_edata_out,
    output logic [NUM_REQ-1:0]                                    resp_valid,
    input  logic [NUM_REQ-1:0]                                    resp_ready,
    output logic [$clog2(TAG_DEPTH):0]                            outstanding,
    output logic                                                  err_orphan,
    output logic                                                  arb_locked
);

    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    arb_state_t arb_state_q, arb_state_d;
    logic [TAG_W-1:0] lock_idx_q, lock_idx_d;
    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] rr_grant;
    logic [TAG_W-1:0] rr_cand;
    logic             rr_found;
    logic [TAG_W-1:0] grant;

    logic [TAG_W-1:0] tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             tag_full, tag_empty;
    logic [TAG_W-1:0] head;
    logic             issue_fire, ret_fire;

    // Round-robin search: first valid requester at or after rr_ptr.
    always_comb begin
        rr_grant = rr_ptr;
        rr_found = 1'b0;
        rr_cand  = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!rr_found && req_valid[rr_cand]) begin
                rr_found = 1'b1;
                rr_grant = rr_cand;
            end
            rr_cand = (rr_cand == TAG_W'(NUM_REQ - 1)) ? '0 : rr_cand + 1'b1;
        end
    end

    // A stalled issue freezes the grant so the beat offered to the cast unit
    // cannot change under it, even if a higher-priority requester shows up.
    assign grant = (arb_state_q == ARB_LOCKED) ? lock_idx_q : rr_grant;

    assign tag_full  = (count == CNT_W'(TAG_DEPTH));
    assign tag_empty = (count == '0);
    assign head      = tag_mem[rd_ptr];

    // Issue path: purely combinational mux, gated off while in reset.
    assign cast_in_valid = rst && (|req_valid) && !tag_full;
    assign cast_mdata_in = req_mdata_in[grant];
    assign cast_edata_in = req_edata_in[grant];
    assign issue_fire    = cast_in_valid && cast_in_ready;

    always_comb begin
        req_ready = '0;
        if (issue_fire) req_ready[grant] = 1'b1;
    end

    // Return path: the head tag selects the owning requester.
    assign cast_out_ready = !tag_empty && resp_ready[head];
    assign ret_fire       = cast_out_valid && cast_out_ready;
    assign resp_mdata_out = cast_mdata_out;
    assign resp_edata_out = cast_edata_out;

    always_comb begin
        resp_valid = '0;
        if (!tag_empty) resp_valid[head] = cast_out_valid;
    end

    assign outstanding = count;
    assign arb_locked  = (arb_state_q == ARB_LOCKED);

    // Arbiter lock FSM.
    always_comb begin
        arb_state_d = arb_state_q;
        lock_idx_d  = lock_idx_q;
        unique case (arb_state_q)
            ARB_FREE: begin
                if (cast_in_valid && !cast_in_ready) begin
                    arb_state_d = ARB_LOCKED;
                    lock_idx_d  = grant;
                end
            end
            ARB_LOCKED: begin
                if (issue_fire) arb_state_d = ARB_FREE;
            end
            default: arb_state_d = ARB_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arb_state_q <= ARB_FREE;
            lock_idx_q  <= '0;
        end else begin
            arb_state_q <= arb_state_d;
            lock_idx_q  <= lock_idx_d;
        end
    end

    // Tag storage carries no reset; validity is tracked by count and pointers.
    always_ff @(posedge clk) begin
        if (issue_fire) tag_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (issue_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (grant == TAG_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
            if (ret_fire) rd_ptr <= rd_ptr + 1'b1;
            unique case ({issue_fire, ret_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (tag_empty && cast_out_valid) err_orphan <= 1'b1;
        end
    end

endmodule
